pipe_sel_mux: RTL and testbench



---
 rtl/pipe_sel_mux.sv | 87 ++++++++
 tb/tb_pipe_sel_mux.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_sel_mux.sv
// Registered N-to-1 select mux with stall/flush control. Illegal selects hold
// out_data, raise out_err for one transfer, and bump a saturating debug counter.
`timescale 1ns/1ps
module pipe_sel_mux #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic                    out_err,
  output logic [CNT_W-1:0]        err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             legal_c;
  logic [WIDTH-1:0] sel_data_c;

  // Channel decode; a select with no matching channel is treated as illegal.
  always_comb begin
    legal_c    = (32'(sel) < NUM_CH);
    sel_data_c = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel == SEL_W'(k)) sel_data_c = in_data[k*WIDTH +: WIDTH];
    end
  end

  // Next-state: flush beats stall beats load; every path holds by default.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (flush) begin
      data_d  = '0;
      valid_d = 1'b0;
      err_d   = 1'b0;
    end else if (!stall) begin
      if (in_valid && legal_c) begin
        data_d  = sel_data_c;
        valid_d = 1'b1;
        err_d   = 1'b0;
      end else if (in_valid) begin
        valid_d = 1'b0;
        err_d   = 1'b1;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      end else begin
        valid_d = 1'b0;
        err_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_err   = err_q;
  assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_pipe_sel_mux.sv
// Directed and random checks of pipe_sel_mux in three configurations:
// 3 channels / 8-bit counter, 3 channels / 2-bit counter, and the default 4 channels.
`timescale 1ns/1ps
module tb_pipe_sel_mux;

  logic         clk = 1'b0;
  logic         reset, in_valid, stall, flush;
  logic [1:0]   sel;
  logic [127:0] in_data;

  logic [31:0] d3_data, dc_data, d4_data;
  logic        d3_valid, d3_err, dc_valid, dc_err, d4_valid, d4_err;
  logic [7:0]  d3_cnt, d4_cnt;
  logic [1:0]  dc_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_sel_mux #(.WIDTH(32), .NUM_CH(3), .SEL_W(2), .CNT_W(8)) dut3 (
    .clk(clk), .reset(reset), .in_data(in_data[95:0]), .sel(sel),
    .in_valid(in_valid), .stall(stall), .flush(flush),
    .out_data(d3_data), .out_valid(d3_valid), .out_err(d3_err), .err_cnt(d3_cnt));

  pipe_sel_mux #(.WIDTH(32), .NUM_CH(3), .SEL_W(2), .CNT_W(2)) dutc (
    .clk(clk), .reset(reset), .in_data(in_data[95:0]), .sel(sel),
    .in_valid(in_valid), .stall(stall), .flush(flush),
    .out_data(dc_data), .out_valid(dc_valid), .out_err(dc_err), .err_cnt(dc_cnt));

  pipe_sel_mux dut4 (
    .clk(clk), .reset(reset), .in_data(in_data), .sel(sel),
    .in_valid(in_valid), .stall(stall), .flush(flush),
    .out_data(d4_data), .out_valid(d4_valid), .out_err(d4_err), .err_cnt(d4_cnt));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [31:0] v);
    in_data[k*32 +: 32] = v;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; sel = 2'd0; stall = 1'b0; flush = 1'b0;
    in_data = '0; set_ch(0, 32'd5);
    tick(); tick();
    total++;
    if ({d3_data, d3_valid, d3_err, d3_cnt} !== {32'd0, 1'b0, 1'b0, 8'd0}) begin
      bad++; $display("FAIL reset_dut3 got=%h/%b/%b/%0d exp=0/0/0/0", d3_data, d3_valid, d3_err, d3_cnt);
    end
    total++;
    if ({dc_data, dc_valid, dc_err, dc_cnt, d4_data, d4_valid, d4_err, d4_cnt} !== '0) begin
      bad++; $display("FAIL reset_others got=%h/%b/%b/%0d %h/%b/%b/%0d exp=all 0",
                      dc_data, dc_valid, dc_err, dc_cnt, d4_data, d4_valid, d4_err, d4_cnt);
    end
    reset = 1'b0; in_valid = 1'b0;
    tick();
    total++;
    if ({d3_data, d3_valid, d3_err} !== {32'd0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL reset_discard got=%h/%b/%b exp=0/0/0", d3_data, d3_valid, d3_err);
    end
  endtask

  task automatic test_select();
    logic [31:0] exp_v [3];
    exp_v = '{32'd100, 32'd55, 32'd93};
    set_ch(0, 32'd100); set_ch(1, 32'd55); set_ch(2, 32'd93); set_ch(3, 32'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sel = 2'(i);
      tick();
      total++;
      if ({d3_data, d3_valid, d3_err} !== {exp_v[i], 1'b1, 1'b0}) begin
        bad++; $display("FAIL select_%0d got=%0d/%b/%b exp=%0d/1/0", i, d3_data, d3_valid, d3_err, exp_v[i]);
      end
    end
  endtask

  task automatic test_illegal();
    sel = 2'd3;
    tick();
    total++;
    if ({d3_data, d3_valid, d3_err, d3_cnt, dc_cnt} !== {32'd93, 1'b0, 1'b1, 8'd1, 2'd1}) begin
      bad++; $display("FAIL illegal got=%0d/%b/%b/%0d/%0d exp=93/0/1/1/1", d3_data, d3_valid, d3_err, d3_cnt, dc_cnt);
    end
    sel = 2'd0; set_ch(0, 32'd15555555);
    tick();
    total++;
    if ({d3_data, d3_valid, d3_err, d3_cnt} !== {32'd15555555, 1'b1, 1'b0, 8'd1}) begin
      bad++; $display("FAIL recover got=%0d/%b/%b/%0d exp=15555555/1/0/1", d3_data, d3_valid, d3_err, d3_cnt);
    end
    in_valid = 1'b0; sel = 2'd3;
    tick();
    total++;
    if ({d3_data, d3_valid, d3_err, d3_cnt} !== {32'd15555555, 1'b0, 1'b0, 8'd1}) begin
      bad++; $display("FAIL idle_hold got=%0d/%b/%b/%0d exp=15555555/0/0/1", d3_data, d3_valid, d3_err, d3_cnt);
    end
  endtask

  task automatic test_stall();
    logic [1:0] ssel [3];
    ssel = '{2'd0, 2'd2, 2'd3};
    in_valid = 1'b1; sel = 2'd1;
    tick();
    total++;
    if ({d3_data, d3_valid, d3_err} !== {32'd55, 1'b1, 1'b0}) begin
      bad++; $display("FAIL stall_pre got=%0d/%b/%b exp=55/1/0", d3_data, d3_valid, d3_err);
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sel = ssel[i]; set_ch(1, 32'(i + 7)); set_ch(2, 32'(i + 20));
      tick();
      total++;
      if ({d3_data, d3_valid, d3_err, d3_cnt} !== {32'd55, 1'b1, 1'b0, 8'd1}) begin
        bad++; $display("FAIL stall_%0d got=%0d/%b/%b/%0d exp=55/1/0/1", i, d3_data, d3_valid, d3_err, d3_cnt);
      end
    end
    stall = 1'b0; sel = 2'd2; set_ch(1, 32'd55); set_ch(2, 32'd93);
    tick();
    total++;
    if ({d3_data, d3_valid, d3_err} !== {32'd93, 1'b1, 1'b0}) begin
      bad++; $display("FAIL stall_release got=%0d/%b/%b exp=93/1/0", d3_data, d3_valid, d3_err);
    end
  endtask

  task automatic test_flush();
    flush = 1'b1; stall = 1'b1; in_valid = 1'b1; sel = 2'd3;
    tick();
    total++;
    if ({d3_data, d3_valid, d3_err, d3_cnt, dc_cnt} !== {32'd0, 1'b0, 1'b0, 8'd1, 2'd1}) begin
      bad++; $display("FAIL flush got=%0d/%b/%b/%0d/%0d exp=0/0/0/1/1", d3_data, d3_valid, d3_err, d3_cnt, dc_cnt);
    end
    flush = 1'b0; stall = 1'b0;
  endtask

  task automatic test_saturate();
    logic [1:0] exp_c [5];
    exp_c = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    reset = 1'b1; in_valid = 1'b0;
    tick();
    reset = 1'b0; in_valid = 1'b1; sel = 2'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({dc_cnt, dc_err, dc_valid, d3_cnt} !== {exp_c[i], 1'b1, 1'b0, 8'(i + 1)}) begin
        bad++; $display("FAIL sat_%0d got=%0d/%b/%b/%0d exp=%0d/1/0/%0d", i, dc_cnt, dc_err, dc_valid, d3_cnt, exp_c[i], i + 1);
      end
    end
    reset = 1'b1;
    tick();
    total++;
    if ({dc_data, dc_valid, dc_err, dc_cnt, d3_cnt} !== '0) begin
      bad++; $display("FAIL sat_reset got=%h/%b/%b/%0d/%0d exp=all 0", dc_data, dc_valid, dc_err, dc_cnt, d3_cnt);
    end
    reset = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_full_ch();
    set_ch(3, 32'hFFFF_FFFF); in_valid = 1'b1; sel = 2'd3;
    tick();
    total++;
    if ({d4_data, d4_valid, d4_err, d4_cnt} !== {32'hFFFF_FFFF, 1'b1, 1'b0, 8'd0}) begin
      bad++; $display("FAIL full_ch3 got=%h/%b/%b/%0d exp=ffffffff/1/0/0", d4_data, d4_valid, d4_err, d4_cnt);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_sweep();
    logic [31:0] m_data;
    logic        m_valid;
    int          nfail;
    reset = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    tick();
    reset = 1'b0;
    m_data = '0; m_valid = 1'b0; nfail = 0;
    for (int c = 0; c < 1000; c++) begin
      for (int k = 0; k < 4; k++) set_ch(k, $urandom);
      sel      = 2'($urandom_range(0, 3));
      in_valid = ($urandom_range(0, 3) != 0);
      stall    = ($urandom_range(0, 4) == 0);
      flush    = ($urandom_range(0, 15) == 0);
      if (flush) begin
        m_data = '0; m_valid = 1'b0;
      end else if (!stall) begin
        if (in_valid) m_data = in_data[32'(sel)*32 +: 32];
        m_valid = in_valid;
      end
      tick();
      total++;
      if ({d4_data, d4_valid, d4_err, d4_cnt} !== {m_data, m_valid, 1'b0, 8'd0}) begin
        bad++; nfail++;
        if (nfail <= 10)
          $display("FAIL sweep_%0d got=%h/%b/%b/%0d exp=%h/%b/0/0", c, d4_data, d4_valid, d4_err, d4_cnt, m_data, m_valid);
      end
    end
    in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_select();
    test_illegal();
    test_stall();
    test_flush();
    test_saturate();
    test_full_ch();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
